// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: size selects, FSM states, strobes.
package dmem_pkg;

    localparam logic [1:0] ST_SW   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SB   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_extender
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  load_sel,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[8*lane +: 8];
    assign half_v = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (load_sel)
            LD_LH:   data = {{16{half_v[15]}}, half_v};
            LD_LHU:  data = {16'h0000, half_v};
            LD_LB:   data = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  data = {24'h000000, byte_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Turns an M-stage load/store into one valid/ready bus transaction, stalling until the
// response (or a timeout) arrives, then returns the extended load result for one cycle.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_M,
    input  logic        write_enable_dmem_M,
    input  logic [31:0] alu_rsl_M,
    input  logic [31:0] wd_M,
    input  logic [1:0]  store_sel_M,
    input  logic [2:0]  load_sel_M,
    output logic        stall_M,
    output logic        misalign_M,
    output logic [31:0] load_data_M,
    output logic        load_valid_M,
    output logic        bus_err_M,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_wstrb_q, bus_wstrb_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             bus_err_q, bus_err_d;
    logic             is_load_q, is_load_d;
    logic [1:0]       lane_q, lane_d;
    logic [2:0]       load_sel_q, load_sel_d;

    logic        acc, misaligned;
    logic [1:0]  lane;
    logic [31:0] st_wdata, ext_data;
    logic [3:0]  st_wstrb;

    assign lane = alu_rsl_M[1:0];
    // A load wins when both strobes are up; a store of size "none" is not an access.
    assign acc  = mem_read_M | (write_enable_dmem_M & (store_sel_M != ST_NONE));

    always_comb begin
        misaligned = 1'b0;
        if (mem_read_M) begin
            case (load_sel_M)
                LD_LH, LD_LHU: misaligned = lane[0];
                LD_LB, LD_LBU: misaligned = 1'b0;
                default:       misaligned = (lane != 2'b00);
            endcase
        end else begin
            case (store_sel_M)
                ST_SW:   misaligned = (lane != 2'b00);
                ST_SH:   misaligned = lane[0];
                default: misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        st_wdata = wd_M;
        st_wstrb = STRB_WORD;
        case (store_sel_M)
            ST_SH: begin
                st_wdata = {2{wd_M[15:0]}};
                st_wstrb = STRB_HALF << lane;
            end
            ST_SB: begin
                st_wdata = {4{wd_M[7:0]}};
                st_wstrb = STRB_BYTE << lane;
            end
            default: ;
        endcase
    end

    load_extender u_load_extender (
        .rdata    (bus_rsp_rdata),
        .lane     (lane_q),
        .load_sel (load_sel_q),
        .data     (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        load_data_d = load_data_q;
        bus_err_d   = bus_err_q;
        is_load_d   = is_load_q;
        lane_d      = lane_q;
        load_sel_d  = load_sel_q;
        case (state_q)
            S_IDLE: begin
                if (acc && !misaligned) begin
                    state_d     = S_REQ;
                    bus_we_d    = !mem_read_M;
                    bus_addr_d  = {alu_rsl_M[31:2], 2'b00};
                    bus_wdata_d = mem_read_M ? 32'h0 : st_wdata;
                    bus_wstrb_d = mem_read_M ? 4'h0 : st_wstrb;
                    is_load_d   = mem_read_M;
                    lane_d      = lane;
                    load_sel_d  = load_sel_M;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the final allowed cycle still beats the timeout.
                if (bus_rsp_valid) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b0;
                    if (is_load_q) begin
                        load_data_d = ext_data;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d     = S_DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = 32'h0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_err_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'h0;
            load_data_q <= 32'h0;
            bus_err_q   <= 1'b0;
            is_load_q   <= 1'b0;
            lane_q      <= 2'b00;
            load_sel_q  <= LD_LW;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
            is_load_q   <= is_load_d;
            lane_q      <= lane_d;
            load_sel_q  <= load_sel_d;
        end
    end

    assign bus_req_valid = (state_q == S_REQ);
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_wstrb     = bus_wstrb_q;
    assign load_data_M   = load_data_q;
    assign bus_err_M     = bus_err_q;
    assign load_valid_M  = (state_q == S_DONE) && is_load_q;
    assign misalign_M    = (state_q == S_IDLE) && acc && misaligned;
    assign stall_M       = (state_q == S_IDLE) ? (acc && !misaligned) : (state_q != S_DONE);

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized scoreboard bench for dmem_access_unit: a driver plays pipeline and memory,
// a negedge monitor compares bus requests and completions against queued expectations.
module tb_dmem_access_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_M, write_enable_dmem_M;
    logic [31:0] alu_rsl_M, wd_M;
    logic [1:0]  store_sel_M;
    logic [2:0]  load_sel_M;
    logic        stall_M, misalign_M, load_valid_M, bus_err_M;
    logic [31:0] load_data_M;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    dmem_access_unit #(.TIMEOUT_CYC(T), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_M(mem_read_M), .write_enable_dmem_M(write_enable_dmem_M),
        .alu_rsl_M(alu_rsl_M), .wd_M(wd_M), .store_sel_M(store_sel_M), .load_sel_M(load_sel_M),
        .stall_M(stall_M), .misalign_M(misalign_M), .load_data_M(load_data_M),
        .load_valid_M(load_valid_M), .bus_err_M(bus_err_M),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } req_t;
    typedef struct { logic is_load; logic [31:0] data; logic err; int stall_cyc; } cpl_t;

    req_t req_q[$];
    cpl_t cpl_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] ln,
                                             input logic [2:0] lsel);
        logic [31:0] b, h;
        b = (rdata >> (8 * ln)) & 32'hFF;
        h = (rdata >> (16 * ln[1])) & 32'hFFFF;
        case (lsel)
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd4:    return b;
            default: return rdata;
        endcase
    endfunction

    // Monitor: request fields on every valid cycle, completion on stall's falling edge.
    logic        prev_stall = 1'b0, last_done = 1'b0;
    int          stall_run = 0;
    logic [31:0] held_data;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_req_valid) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected actual=valid expected=idle at %0t", $time);
                end else begin
                    chk("req_we", bus_we, req_q[0].we);
                    chk("req_addr", bus_addr, req_q[0].addr);
                    chk("req_strb", bus_wstrb, req_q[0].strb);
                    if (req_q[0].we) chk("req_wdata", bus_wdata, req_q[0].wdata);
                    if (bus_req_ready) void'(req_q.pop_front());
                end
            end
            if (stall_M) begin
                stall_run++;
            end else begin
                if (prev_stall) begin
                    if (cpl_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cpl_unexpected actual=done expected=none at %0t", $time);
                    end else begin
                        cpl_t c;
                        c = cpl_q.pop_front();
                        chk("done_valid", load_valid_M, c.is_load);
                        chk("done_err", bus_err_M, c.err);
                        chk("stall_cycles", stall_run, c.stall_cyc);
                        if (c.is_load || c.err) chk("done_data", load_data_M, c.data);
                    end
                    last_done = 1'b1;
                    held_data = load_data_M;
                end else if (last_done) begin
                    chk("valid_drop", load_valid_M, 1'b0);
                    chk("err_drop", bus_err_M, 1'b0);
                    chk("data_hold", load_data_M, held_data);
                    last_done = 1'b0;
                end
                stall_run = 0;
            end
            prev_stall = stall_M;
        end
    end

    task automatic clear_inputs();
        mem_read_M = 1'b0; write_enable_dmem_M = 1'b0;
        alu_rsl_M = 32'h0; wd_M = 32'h0; store_sel_M = 2'b11; load_sel_M = 3'b000;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;
    endtask

    // rdly: cycles ready stays low in REQ; dly: WAIT cycles before rsp (>= T means none).
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] ssel, input logic [2:0] lsel,
                          input int rdly, input int dly, input logic [31:0] rdata);
        int   size;
        logic acc, mis;
        req_t r;
        cpl_t c;
        acc = rd || (wr && ssel != 2'b11);
        if (rd) size = (lsel == 3'd1 || lsel == 3'd2) ? 2 : (lsel == 3'd3 || lsel == 3'd4) ? 1 : 4;
        else    size = (ssel == 2'b00) ? 4 : (ssel == 2'b01) ? 2 : 1;
        mis = acc && ((addr % size) != 0);

        @(posedge clk); #1;
        mem_read_M = rd; write_enable_dmem_M = wr; alu_rsl_M = addr; wd_M = wd;
        store_sel_M = ssel; load_sel_M = lsel;
        bus_rsp_valid = 1'($urandom_range(0, 1)); bus_rsp_rdata = $urandom;
        if (acc && !mis) begin
            r.we   = !rd;
            r.addr = addr & ~32'h3;
            r.wdata = (size == 4) ? wd : (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001
                                                     : (wd & 32'hFF) * 32'h0101_0101;
            r.strb = rd ? 4'h0 : (size == 4) ? 4'hF : (size == 2) ? (4'b0011 << addr[1:0])
                                                                    : (4'b0001 << addr[1:0]);
            req_q.push_back(r);
            c.is_load   = rd;
            c.err       = (dly >= T);
            c.data      = (dly >= T) ? 32'h0 : ref_load(rdata, addr[1:0], lsel);
            c.stall_cyc = 2 + rdly + ((dly >= T) ? T : dly + 1);
            cpl_q.push_back(c);
        end
        @(negedge clk);
        chk("misalign", misalign_M, mis);
        chk("idle_stall", stall_M, acc && !mis);
        if (!(acc && !mis)) begin
            chk("no_req", bus_req_valid, 1'b0);
            @(posedge clk); #1;
            clear_inputs();
            return;
        end
        @(posedge clk); #1;
        for (int i = 0; i < rdly; i++) begin
            bus_rsp_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus_rsp_valid = 1'b0; bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        if (dly < T) begin
            repeat (dly) begin @(posedge clk); #1; end
            bus_rsp_valid = 1'b1; bus_rsp_rdata = rdata;
            @(posedge clk); #1;
        end else begin
            repeat (T) begin @(posedge clk); #1; end
        end
        bus_rsp_valid = 1'($urandom_range(0, 1)); bus_rsp_rdata = $urandom;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall_M, 1'b0);
        chk("rst_req_valid", bus_req_valid, 1'b0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_strb", bus_wstrb, 4'h0);
        chk("rst_valid", load_valid_M, 1'b0);
        chk("rst_err", bus_err_M, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'b00, 3'd0, 0, 0, 32'h0);
        access(1'b0, 1'b1, 32'h203, 32'h000000A5, 2'b10, 3'd0, 0, 0, 32'h0);
        access(1'b1, 1'b0, 32'h102, 32'h0, 2'b11, 3'd3, 0, 0, 32'h12F03456);
        access(1'b1, 1'b0, 32'h102, 32'h0, 2'b11, 3'd4, 0, 1, 32'h12F03456);
        access(1'b1, 1'b0, 32'h102, 32'h0, 2'b11, 3'd1, 1, 0, 32'h12F03456);
        access(1'b1, 1'b0, 32'h101, 32'h0, 2'b11, 3'd0, 0, 0, 32'h0);
        access(1'b0, 1'b1, 32'h103, 32'h1234, 2'b01, 3'd0, 0, 0, 32'h0);
        access(1'b0, 1'b1, 32'h300, 32'h5555AAAA, 2'b00, 3'd0, 5, 2, 32'h0);
        access(1'b1, 1'b0, 32'h400, 32'h0, 2'b11, 3'd0, 0, T, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'h404, 32'h0, 2'b11, 3'd0, 0, T - 1, 32'hCAFEF00D);
        access(1'b0, 1'b1, 32'h500, 32'h1, 2'b11, 3'd0, 0, 0, 32'h0);
        access(1'b1, 1'b1, 32'h606, 32'hFFFF, 2'b10, 3'd2, 0, 0, 32'h8001_7FFF);

        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic        rd, wr;
            logic [1:0]  ssel;
            kind = $urandom_range(0, 9);
            rd   = (kind <= 3) || (kind == 8);
            wr   = (kind >= 4 && kind <= 8) || (kind == 9 && $urandom_range(0, 1) == 1);
            ssel = (kind == 9) ? 2'b11 : 2'($urandom_range(0, 2));
            access(rd, wr, $urandom, $urandom, ssel, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom_range(0, T + 1), $urandom);
        end

        repeat (2) @(posedge clk);
        mon_en = 1'b0;
        @(posedge clk); #1;
        mem_read_M = 1'b1; alu_rsl_M = 32'h40; load_sel_M = 3'd0;
        @(posedge clk); #1;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h89ABCDEF;
        @(negedge clk);
        chk("midrst_stall", stall_M, 1'b0);
        chk("midrst_req_valid", bus_req_valid, 1'b0);
        chk("midrst_we", bus_we, 1'b0);
        chk("midrst_addr", bus_addr, 32'h0);
        chk("midrst_wdata", bus_wdata, 32'h0);
        chk("midrst_strb", bus_wstrb, 4'h0);
        chk("midrst_data", load_data_M, 32'h0);
        chk("midrst_valid", load_valid_M, 1'b0);
        chk("midrst_err", bus_err_M, 1'b0);
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stray_valid", load_valid_M, 1'b0);
            chk("stray_data", load_data_M, 32'h0);
            chk("stray_stall", stall_M, 1'b0);
        end
        if (req_q.size() != 0 || cpl_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL queues_drained actual=%0d/%0d expected=0/0", req_q.size(), cpl_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

endmodule
